// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types and seven-segment constants for the frequency meter
package freq_meter_pkg;

    // One BCD digit of the edge count
    typedef logic [3:0] bcd_t;

    // Active-low segment codes, bit order {a,b,c,d,e,f,g,dp}
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'b1111_1101;

    localparam logic [7:0] SEG_DIGIT [10] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
        8'h49, 8'h41, 8'h1F, 8'h01, 8'h09
    };

    // Counter width for a modulus n, never narrower than one bit
    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD digit to active-low seven-segment code with blank and dash overrides
module seg7_decode
    import freq_meter_pkg::*;
(
    input  bcd_t       bcd,
    input  logic       blank,
    input  logic       dash,
    output logic [7:0] segment
);

    // Dash wins over blanking; non-decimal nibbles show nothing
    always_comb begin
        segment = SEG_BLANK;
        if (dash) begin
            segment = SEG_DASH;
        end else if (!blank && (bcd <= 4'd9)) begin
            segment = SEG_DIGIT[bcd];
        end
    end

endmodule

// File: rtl/freq_meter_mux.sv
// rtl/freq_meter_mux.sv - gated BCD frequency counter with multiplexed seven-segment display
module freq_meter_mux
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int DIGITS      = 4,
    parameter int SCAN_CYCLES = 50_000,
    parameter int LZ_BLANK    = 1
) (
    input  logic                  clck,
    input  logic                  rst_n,
    input  logic                  sigin,
    input  logic                  hold,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  ovf,
    output logic                  valid,
    output logic [DIGITS-1:0]     digit,
    output logic [7:0]            segment
);

    localparam int TW = ctr_width(GATE_CYCLES);
    localparam int SW = ctr_width(SCAN_CYCLES);
    localparam int IW = ctr_width(DIGITS);

    localparam logic [TW-1:0] GATE_LAST  = TW'(GATE_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_CYCLES - 1);
    localparam logic [IW-1:0] DIGIT_LAST = IW'(DIGITS - 1);

    logic [1:0]             sync;
    logic                   sig_prev;
    logic                   rise;
    logic                   run;
    logic [TW-1:0]          gate_cnt;
    logic                   terminal;
    bcd_t [DIGITS-1:0]      cnt;
    bcd_t [DIGITS-1:0]      cnt_nxt;
    logic                   win_ovf;
    logic                   win_ovf_nxt;
    logic                   all_nine;
    logic                   carry;
    logic [SW-1:0]          scan_cnt;
    logic [IW-1:0]          scan_idx;
    bcd_t [DIGITS-1:0]      disp;
    logic [DIGITS-1:0]      lz;
    logic                   nz_above;
    bcd_t                   cur_bcd;
    logic                   cur_blank;

    // Two-flop synchronizer plus one history flop for rising-edge detection
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= 2'b00;
            sig_prev <= 1'b0;
        end else begin
            sync     <= {sync[0], sigin};
            sig_prev <= sync[1];
        end
    end

    assign rise = sync[1] & ~sig_prev;

    // Reset release is retimed so the gate timer starts on the second edge after rst_n rises
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    assign terminal = run && (gate_cnt == GATE_LAST);

    // Gate timer walks 0..GATE_CYCLES-1 and wraps
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt <= '0;
        end else if (run) begin
            gate_cnt <= terminal ? '0 : gate_cnt + TW'(1);
        end
    end

    // Next count: cascaded BCD increment, saturating at all-9s with a sticky overflow
    always_comb begin
        cnt_nxt     = cnt;
        win_ovf_nxt = win_ovf;
        all_nine    = 1'b1;
        carry       = rise;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt[i] != 4'd9) begin
                all_nine = 1'b0;
            end
        end
        if (rise && all_nine) begin
            win_ovf_nxt = 1'b1;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (cnt[i] == 4'd9) begin
                        cnt_nxt[i] = 4'd0;
                    end else begin
                        cnt_nxt[i] = cnt[i] + 4'd1;
                        carry      = 1'b0;
                    end
                end
            end
        end
    end

    // Window counter clears on the terminal cycle regardless of hold
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            win_ovf <= 1'b0;
        end else if (terminal) begin
            cnt     <= '0;
            win_ovf <= 1'b0;
        end else if (run) begin
            cnt     <= cnt_nxt;
            win_ovf <= win_ovf_nxt;
        end
    end

    // Latch the closing window, including an edge seen on the terminal cycle itself
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            count_bcd <= '0;
            ovf       <= 1'b0;
            valid     <= 1'b0;
        end else begin
            valid <= terminal && !hold;
            if (terminal && !hold) begin
                count_bcd <= cnt_nxt;
                ovf       <= win_ovf_nxt;
            end
        end
    end

    // Display scan: dwell SCAN_CYCLES on each digit, cycling through all of them
    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (run) begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == DIGIT_LAST) ? '0 : scan_idx + IW'(1);
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end
        end
    end

    assign disp = count_bcd;

    // Leading-zero mask: a digit blanks when it and everything above it is zero
    always_comb begin
        nz_above = 1'b0;
        lz       = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (disp[i] != 4'd0) begin
                nz_above = 1'b1;
            end
            lz[i] = (LZ_BLANK != 0) && (i != 0) && !nz_above;
        end
    end

    assign cur_bcd   = disp[scan_idx];
    assign cur_blank = lz[scan_idx];
    assign digit     = ~(DIGITS'(1) << scan_idx);

    seg7_decode u_seg7_decode (
        .bcd     (cur_bcd),
        .blank   (cur_blank),
        .dash    (ovf),
        .segment (segment)
    );

endmodule

// File: tb/tb_freq_meter_mux.sv
// tb/tb_freq_meter_mux.sv - scoreboard bench for freq_meter_mux
module tb_freq_meter_mux;

    logic        clck    = 1'b0;
    logic        rst_n   = 1'b0;
    logic        sigin   = 1'b0;
    logic        sigin2  = 1'b0;
    logic        hold    = 1'b0;
    logic [15:0] count_bcd;
    logic        ovf;
    logic        valid;
    logic [3:0]  digit;
    logic [7:0]  segment;
    logic [7:0]  count2;
    logic        ovf2;
    logic        valid2;
    logic [1:0]  digit2;
    logic [7:0]  segment2;

    int n_vec  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int tper   = 0;
    int tcnt   = 0;
    logic man_lvl = 1'b0;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
    } exp_t;
    exp_t expq[$];

    freq_meter_mux #(
        .GATE_CYCLES (1000),
        .DIGITS      (4),
        .SCAN_CYCLES (4),
        .LZ_BLANK    (1)
    ) dut (
        .clck      (clck),
        .rst_n     (rst_n),
        .sigin     (sigin),
        .hold      (hold),
        .count_bcd (count_bcd),
        .ovf       (ovf),
        .valid     (valid),
        .digit     (digit),
        .segment   (segment)
    );

    freq_meter_mux #(
        .GATE_CYCLES (1000),
        .DIGITS      (2),
        .SCAN_CYCLES (4),
        .LZ_BLANK    (1)
    ) dut2 (
        .clck      (clck),
        .rst_n     (rst_n),
        .sigin     (sigin2),
        .hold      (1'b0),
        .count_bcd (count2),
        .ovf       (ovf2),
        .valid     (valid2),
        .digit     (digit2),
        .segment   (segment2)
    );

    initial forever #5 clck = ~clck;

    always @(posedge clck) cyc++;

    // sigin: toggles every tper cycles when tper is nonzero, otherwise follows man_lvl
    initial forever begin
        @(posedge clck);
        #1;
        if (tper != 0) begin
            tcnt++;
            if (tcnt >= tper) begin
                sigin = ~sigin;
                tcnt  = 0;
            end
        end else begin
            sigin = man_lvl;
        end
    end

    // sigin2 toggles every cycle: 500 rising edges per window
    initial forever begin
        @(posedge clck);
        #1;
        sigin2 = ~sigin2;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] bcd, input logic o);
        exp_t e;
        e.bcd = bcd;
        e.ovf = o;
        expq.push_back(e);
    endtask

    // Monitor: every valid pulse must match the oldest expected window result
    always @(negedge clck) begin : mon
        exp_t e;
        if (valid) begin
            if (expq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: got count %h ovf %b expected no valid", count_bcd, ovf);
            end else begin
                e = expq.pop_front();
                check("window_result", {count_bcd, ovf}, {e.bcd, e.ovf});
            end
        end
    end

    // Every window of the two-digit instance saturates
    always @(negedge clck) begin
        if (valid2) begin
            check("ovf_window", {count2, ovf2}, {8'h99, 1'b1});
        end
    end

    task automatic wait_edge(input int e);
        while (cyc < e) @(negedge clck);
    endtask

    task automatic sync_valid(input string name);
        bit got;
        got = 0;
        for (int i = 0; i < 1200 && !got; i++) begin
            @(negedge clck);
            if (valid) got = 1;
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got no valid expected valid within 1200 cycles", name);
        end
    endtask

    task automatic disp_check(input string name, input logic [31:0] segs);
        logic [3:0] want;
        bit got;
        for (int i = 0; i < 4; i++) begin
            want = ~(4'b0001 << i);
            got  = 0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clck);
                if (digit == want) got = 1;
            end
            if (got) begin
                check(name, {digit, segment}, {want, segs[i*8 +: 8]});
            end else begin
                check(name, {digit, segment}, {want, 8'hxx});
            end
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_count"},   count_bcd, 16'h0000);
        check({tag, "_ovf"},     ovf,       1'b0);
        check({tag, "_valid"},   valid,     1'b0);
        check({tag, "_digit"},   digit,     4'b1110);
        check({tag, "_segment"}, segment,   8'b0000_0011);
    endtask

    initial begin : stim
        logic [63:0] cap;
        logic [3:0]  prev;
        logic [1:0]  want2;
        bit          got;
        int          t0;
        int          n;

        repeat (3) @(posedge clck);
        #2;
        reset_checks("reset");

        @(negedge clck);
        rst_n = 1'b1;
        push_exp(16'h0000, 1'b0);

        // Idle scan sequence and leading-zero blanking of 0000
        prev = digit;
        got  = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clck);
            if (prev == 4'b1110 && digit == 4'b1101) got = 1;
            prev = digit;
        end
        cap = {60'b0, digit};
        for (int k = 1; k < 16; k++) begin
            @(negedge clck);
            cap = {cap[59:0], digit};
        end
        check("scan_seq", cap, 64'hDDDD_BBBB_7777_EEEE);
        disp_check("idle_display", {8'hFF, 8'hFF, 8'hFF, 8'h03});

        // 50 rising edges per window
        sync_valid("w1");
        tper = 10;
        tcnt = 0;
        push_exp(16'h0050, 1'b0);
        push_exp(16'h0050, 1'b0);
        sync_valid("w2");
        sync_valid("w3");

        // Hold across one terminal cycle, then double the frequency
        t0   = cyc;
        hold = 1'b1;
        disp_check("count_display", {8'hFF, 8'hFF, 8'h49, 8'h03});
        wait_edge(t0 + 989);
        @(posedge clck);
        #2;
        tper = 5;
        tcnt = 0;
        wait_edge(t0 + 1005);
        check("hold_count", count_bcd, 16'h0050);
        check("hold_ovf", ovf, 1'b0);
        hold = 1'b0;
        push_exp(16'h0100, 1'b0);
        sync_valid("w5");

        // Reset in the middle of a window
        t0 = cyc;
        wait_edge(t0 + 499);
        @(posedge clck);
        #2;
        tper    = 0;
        man_lvl = 1'b0;
        rst_n   = 1'b0;
        #1;
        reset_checks("midreset");
        repeat (3) @(negedge clck);
        rst_n = 1'b1;
        push_exp(16'h0000, 1'b0);
        n   = 0;
        got = 0;
        for (int k = 0; k < 1100 && !got; k++) begin
            @(posedge clck);
            n++;
            #1;
            if (valid) got = 1;
        end
        check("release_to_valid", n, 1001);

        // Single edge detected on the terminal cycle
        @(negedge clck);
        t0 = cyc;
        push_exp(16'h0001, 1'b0);
        push_exp(16'h0000, 1'b0);
        wait_edge(t0 + 996);
        man_lvl = 1'b1;
        wait_edge(t0 + 1020);
        man_lvl = 1'b0;
        sync_valid("w_after_single");

        // Overflowed two-digit display shows dashes everywhere
        for (int i = 0; i < 2; i++) begin
            want2 = ~(2'b01 << i);
            got   = 0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clck);
                if (digit2 == want2) got = 1;
            end
            check("ovf_display", {digit2, segment2}, {want2, 8'b1111_1101});
        end

        check("pending_results", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/freq_meter_mux.md
FREQ_METER_MUX -- requirements
Module: freq_meter_mux

Interface
REQ-001 Parameter GATE_CYCLES, default 50_000_000, clck cycles per measurement window (1 s at 50 MHz).
REQ-002 Parameter DIGITS, default 4, number of BCD digits counted and displayed (range 1..8).
REQ-003 Parameter SCAN_CYCLES, default 50_000, clck cycles each digit is driven during display multiplexing.
REQ-004 Parameter LZ_BLANK, default 1, 1 = blank leading zeros (least-significant digit never blanked).
REQ-005 clck  in  1  system clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 sigin  in  1  asynchronous measured square wave.
REQ-008 hold  in  1  1 = freeze displayed value; counting continues.
REQ-009 count_bcd  out  4*DIGITS  last latched count, BCD, digit 0 in [3:0].
REQ-010 ovf  out  1  last latched window exceeded 10^DIGITS-1 edges.
REQ-011 valid  out  1  one-cycle pulse when count_bcd/ovf update.
REQ-012 digit  out  DIGITS  active-low one-hot digit enable.
REQ-013 segment  out  8  active-low segments {a,b,c,d,e,f,g,dp}.

Function
REQ-014 sigin SHALL pass a 2-flop synchronizer; a rising edge is sync[1]=1 with previous sample 0; edge-to-count latency 3 cycles.
REQ-015 Gate timer SHALL count 0..GATE_CYCLES-1 and wrap to 0; cycle GATE_CYCLES-1 is the terminal cycle.
REQ-016 Edge counter SHALL be a DIGITS-digit cascaded BCD counter, each digit 9->0 with carry into the next.
REQ-017 Counter at all-9s receiving an edge SHALL hold all-9s and set a sticky window-overflow bit.
REQ-018 On the terminal cycle, an edge detected in that same cycle SHALL be included in the closing window.
REQ-019 On the terminal cycle, the registered count (including REQ-018 edge) and overflow bit SHALL load count_bcd/ovf one cycle later, with valid=1 that cycle, unless hold=1.
REQ-020 On the terminal cycle the counter and overflow bit SHALL clear so the next window starts at 0; independent of hold.
REQ-021 hold=1 at terminal cycle: count_bcd, ovf unchanged, valid stays 0; window result discarded.
REQ-022 Scan counter SHALL advance digit index every SCAN_CYCLES cycles, 0..DIGITS-1, wrapping to 0.
REQ-023 digit SHALL drive exactly one bit low (index = scan index) at all times after reset.
REQ-024 segment SHALL show the 7-seg code of count_bcd nibble at scan index; dp always off (1).
REQ-025 ovf=1: every digit SHALL show '-' (segment = 8'b1111_1101).
REQ-026 LZ_BLANK=1: digit i>0 SHALL show blank (8'hFF) when it and all higher digits are 0.
REQ-027 Nibble values 10..15 (unreachable) SHALL decode to blank.
REQ-028 Display SHALL reflect count_bcd from the cycle after valid with no glitch to other values.

Reset
REQ-029 rst_n=0 SHALL immediately clear synchronizer, gate timer, edge counter, overflow bits, count_bcd, ovf, valid, scan index.
REQ-030 During reset digit = all 1s except bit 0 low; segment = code for '0' (8'b0000_0011).
REQ-031 Reset mid-window SHALL discard the partial count; first window after release is full GATE_CYCLES long.
REQ-032 Reset release is synchronised internally; first timer increment on the second clck edge after rst_n rises.

Structure
REQ-033 Package freq_meter_pkg SHALL hold segment constants (SEG_BLANK, SEG_DASH, digit 0-9 table) and the BCD digit type.
REQ-034 One sub-module seg7_decode (4-bit BCD + blank + dash -> 8-bit segment) is instantiated once after the scan mux.
REQ-035 Timer and scan counter widths SHALL be $clog2 of their parameters; no other arithmetic is wider.

Verification (GATE_CYCLES=1000, DIGITS=4, SCAN_CYCLES=4)
REQ-036 sigin toggles every 10 cycles -> after second window valid pulse, count_bcd=16'h0050, ovf=0; digits show blank,blank,5,0.
REQ-037 sigin toggles every cycle with DIGITS=2 -> count_bcd=8'h99, ovf=1, both digits show 8'b1111_1101.
REQ-038 Single edge aligned to terminal cycle -> counted in closing window (16'h0001), next window 16'h0000.
REQ-039 hold=1 across one terminal cycle at 50 edges then frequency doubled -> no valid, count_bcd stays 0050; after hold=0 next valid shows 0100.
REQ-040 rst_n pulsed low at cycle 500 of a window -> outputs at reset values immediately; next valid exactly 1000 cycles after release sync.
REQ-041 Idle sigin=0 -> digit sequence 1110,1101,1011,0111 every 4 cycles, count 0000 shown as blank,blank,blank,0.
